dvi_timing_ctrl: RTL and testbench

- Video timing generator and pixel-stream scheduler that drives the DVI encoder's blue/green/red, hsync, vsync and de inputs.
- Produces raster timing from parameters and pulls pixels from an upstream valid/ready stream (camera/frame-buffer path) only during active video.
- Aligns frames on a start-of-frame marker; on underflow or misalignment it blanks output and resynchronises at the next frame.

---
 rtl/dvi_timing_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_dvi_timing_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_timing_ctrl.sv
// dvi_timing_ctrl
//   Raster timing generator and pixel scheduler feeding a DVI encoder.
//   Pixels are pulled from an upstream valid/ready stream only during
//   active video. A frame is locked onto the start-of-frame marker at raster
//   position (0,0). On underflow or a misplaced SOF the output is blanked and
//   the block waits for the next SOF at (0,0).
//
//   Optional build macro: DVI_TEST_PATTERN_EN
//     When defined, adds input pattern_sel. With pattern_sel=1 the active area
//     shows 8 colour bars and the upstream stream is left untouched.
//
// Ports
//   pixelclk      pixel clock; all logic runs in this domain
//   rstin_n       asynchronous active-low reset
//   enable        1 = run timing, 0 = idle (counters at 0, outputs idle)
//   s_data        upstream pixel {R,G,B}
//   s_valid       upstream pixel valid
//   s_sof         first pixel of a frame (qualified by s_valid)
//   s_ready       pixel accepted when s_valid & s_ready
//   red_out       encoder red input
//   green_out     encoder green input
//   blue_out      encoder blue input
//   hsync/vsync   sync outputs, active level set by HS_POL/VS_POL
//   de            data enable (active video)
//   frame_start   one-cycle pulse alongside output pixel (0,0)
//   underflow     sticky error flag (underflow or misaligned SOF)
//   pattern_sel   colour-bar select (DVI_TEST_PATTERN_EN builds only)
//   clr_underflow synchronous clear of underflow (a new error wins)
module dvi_timing_ctrl #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        pixelclk,
  input  logic        rstin_n,
  input  logic        enable,
  input  logic [23:0] s_data,
  input  logic        s_valid,
  input  logic        s_sof,
  output logic        s_ready,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic        underflow,
`ifdef DVI_TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  input  logic        clr_underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // Boundaries kept 32 bits wide so that comparisons never truncate,
  // even when a sync window ends exactly at the line/frame total.
  localparam logic [31:0] H_ACT_L  = H_ACTIVE;
  localparam logic [31:0] H_LAST_L = H_TOTAL - 1;
  localparam logic [31:0] HS_BEG_L = H_ACTIVE + H_FP;
  localparam logic [31:0] HS_END_L = H_ACTIVE + H_FP + H_SYNC;
  localparam logic [31:0] V_ACT_L  = V_ACTIVE;
  localparam logic [31:0] V_LAST_L = V_TOTAL - 1;
  localparam logic [31:0] VS_BEG_L = V_ACTIVE + V_FP;
  localparam logic [31:0] VS_END_L = V_ACTIVE + V_FP + V_SYNC;

  typedef enum logic {WAIT_SOF = 1'b0, RUN = 1'b1} state_t;

  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;
  logic [31:0]   h_pos;
  logic [31:0]   v_pos;
  logic          at_origin;
  logic          active;
  logic          hs_win;
  logic          vs_win;

  state_t        state_reg;
  state_t        state_next;
  logic          misalign;
  logic          take_pixel;
  logic          err_set;
  logic [23:0]   rgb_next;

  logic [23:0]   rgb_reg;
  logic          de_reg;
  logic          hsync_reg;
  logic          vsync_reg;
  logic          frame_start_reg;
  logic          underflow_reg;

  logic          pattern_on;
  logic [23:0]   pattern_rgb;

  // ---------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------
  assign h_pos     = 32'(h_cnt_reg);
  assign v_pos     = 32'(v_cnt_reg);
  assign at_origin = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  assign active    = (h_pos < H_ACT_L) && (v_pos < V_ACT_L);
  assign hs_win    = (h_pos >= HS_BEG_L) && (h_pos < HS_END_L);
  assign vs_win    = (v_pos >= VS_BEG_L) && (v_pos < VS_END_L);

  always_ff @(posedge pixelclk or negedge rstin_n) begin
    if (!rstin_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (!enable) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_pos == H_LAST_L) begin
      h_cnt_reg <= '0;
      if (v_pos == V_LAST_L) begin
        v_cnt_reg <= '0;
      end else begin
        v_cnt_reg <= v_cnt_reg + 1'b1;
      end
    end else begin
      h_cnt_reg <= h_cnt_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Colour bars
  // ---------------------------------------------------------------------
`ifdef DVI_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [6:0] bar_ge;
  logic [2:0] bar_idx;

  // Thermometer of bar edges; the last bar has no upper edge, so it
  // absorbs any remainder of H_ACTIVE/8.
  genvar gi;
  for (gi = 0; gi < 7; gi++) begin : g_bar
    localparam logic [31:0] EDGE = (gi + 1) * BAR_W;
    assign bar_ge[gi] = (h_pos >= EDGE);
  end

  always_comb begin
    bar_idx = 3'd0;
    for (int i = 0; i < 7; i++) begin
      bar_idx = bar_idx + {2'b00, bar_ge[i]};
    end
  end

  // Bar order white, yellow, cyan, green, magenta, red, blue, black maps to
  // R = ~idx[1], G = ~idx[2], B = ~idx[0].
  assign pattern_on  = pattern_sel;
  assign pattern_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
`else
  assign pattern_on  = 1'b0;
  assign pattern_rgb = 24'h000000;
`endif

  // ---------------------------------------------------------------------
  // Stream FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge pixelclk or negedge rstin_n) begin
    if (!rstin_n) begin
      state_reg <= WAIT_SOF;
    end else begin
      state_reg <= state_next;
    end
  end

  // SOF seen anywhere other than (0,0) means the source is out of step.
  assign misalign = s_valid && s_sof && !at_origin;

  // Stream FSM: next state
  always_comb begin
    state_next = state_reg;
    if (!enable || pattern_on) begin
      state_next = WAIT_SOF;
    end else begin
      case (state_reg)
        WAIT_SOF: if (at_origin && s_valid && s_sof) state_next = RUN;
        RUN:      if (active && (!s_valid || misalign)) state_next = WAIT_SOF;
        default:  state_next = WAIT_SOF;
      endcase
    end
  end

  // Stream FSM: outputs
  always_comb begin
    s_ready    = 1'b0;
    take_pixel = 1'b0;
    err_set    = 1'b0;
    if (enable && !pattern_on) begin
      case (state_reg)
        WAIT_SOF: begin
          // Drain stale pixels; hold an early SOF until the raster reaches
          // (0,0), where it is consumed.
          s_ready    = s_valid && (!s_sof || at_origin);
          take_pixel = at_origin && s_valid && s_sof;
        end
        RUN: begin
          s_ready    = active && !misalign;
          take_pixel = active && s_valid && !misalign;
          err_set    = active && !take_pixel;
        end
        default: ;
      endcase
    end

    rgb_next = 24'h000000;
    if (pattern_on && active) begin
      rgb_next = pattern_rgb;
    end else if (take_pixel) begin
      rgb_next = s_data;
    end
  end

  // ---------------------------------------------------------------------
  // Registered video outputs (one clock after the counters)
  // ---------------------------------------------------------------------
  always_ff @(posedge pixelclk or negedge rstin_n) begin
    if (!rstin_n) begin
      rgb_reg         <= 24'h000000;
      de_reg          <= 1'b0;
      hsync_reg       <= ~HS_POL;
      vsync_reg       <= ~VS_POL;
      frame_start_reg <= 1'b0;
    end else if (!enable) begin
      rgb_reg         <= 24'h000000;
      de_reg          <= 1'b0;
      hsync_reg       <= ~HS_POL;
      vsync_reg       <= ~VS_POL;
      frame_start_reg <= 1'b0;
    end else begin
      rgb_reg         <= rgb_next;
      de_reg          <= active;
      hsync_reg       <= hs_win ? HS_POL : ~HS_POL;
      vsync_reg       <= vs_win ? VS_POL : ~VS_POL;
      frame_start_reg <= at_origin;
    end
  end

  // Sticky error flag; a new error in the same cycle overrides a clear.
  always_ff @(posedge pixelclk or negedge rstin_n) begin
    if (!rstin_n) begin
      underflow_reg <= 1'b0;
    end else if (err_set) begin
      underflow_reg <= 1'b1;
    end else if (clr_underflow) begin
      underflow_reg <= 1'b0;
    end
  end

  assign red_out     = rgb_reg[23:16];
  assign green_out   = rgb_reg[15:8];
  assign blue_out    = rgb_reg[7:0];
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign de          = de_reg;
  assign frame_start = frame_start_reg;
  assign underflow   = underflow_reg;

endmodule

// File: tb/tb_dvi_timing_ctrl.sv
// tb_dvi_timing_ctrl
//   Directed bench for dvi_timing_ctrl with a small raster:
//   H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), 98 clocks per frame.
//   Expected values come from the raster formulas and the scripted stimulus.
module tb_dvi_timing_ctrl;

  localparam int HT = 14;
  localparam int FT = 98;

  logic        pixelclk = 1'b0;
  logic        rstin_n;
  logic        enable;
  logic [23:0] s_data;
  logic        s_valid;
  logic        s_sof;
  logic        s_ready;
  logic [7:0]  red_out;
  logic [7:0]  green_out;
  logic [7:0]  blue_out;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;
  logic        underflow;
  logic        clr_underflow;
`ifdef DVI_TEST_PATTERN_EN
  logic        pattern_sel;
`endif

  int checks = 0;
  int errors = 0;
  int pos = 0;        // raster position held in the counters right now
  int last_pos = 0;   // position reflected by the registered outputs
  bit last_en = 0;    // whether that edge ran with enable and out of reset
  bit exp_run = 0;    // expected FSM state is RUN
  int wait_mode = 0;  // upstream behaviour while waiting: 0 idle, 1 drain, 2 hold SOF
  bit exp_uf = 0;

  dvi_timing_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .pixelclk      (pixelclk),
    .rstin_n       (rstin_n),
    .enable        (enable),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_sof         (s_sof),
    .s_ready       (s_ready),
    .red_out       (red_out),
    .green_out     (green_out),
    .blue_out      (blue_out),
    .hsync         (hsync),
    .vsync         (vsync),
    .de            (de),
    .frame_start   (frame_start),
    .underflow     (underflow),
`ifdef DVI_TEST_PATTERN_EN
    .pattern_sel   (pattern_sel),
`endif
    .clr_underflow (clr_underflow)
  );

  always #5 pixelclk = ~pixelclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit f_act(input int p);
    return ((p % HT) < 8) && ((p / HT) < 4);
  endfunction

  function automatic bit f_hs(input int p);
    return ((p % HT) >= 10) && ((p % HT) < 12);
  endfunction

  function automatic bit f_vs(input int p);
    return (p / HT) == 5;
  endfunction

  task automatic tick();
    @(posedge pixelclk);
    last_pos = pos;
    last_en  = enable && rstin_n;
    pos      = (enable && rstin_n) ? (pos + 1) % FT : 0;
    #1;
  endtask

  // {de, hsync, vsync, frame_start} against the raster formulas
  task automatic check_timing(input string tag);
    logic [3:0] exp;
    exp = last_en ? {f_act(last_pos), f_hs(last_pos), f_vs(last_pos), (last_pos == 0)} : 4'b0000;
    check(tag, 32'({de, hsync, vsync, frame_start}), 32'(exp));
  endtask

  task automatic check_rgb(input string tag, input logic [23:0] exp);
    check(tag, 32'({red_out, green_out, blue_out}), 32'(exp));
  endtask

  // One full frame from position 0. The upstream source presents pixel base+n;
  // drop_at removes valid for pixel n, sof_at raises a stray SOF on pixel n,
  // clr_a/clr_b pulse clr_underflow at raster cycle c, stop_at ends early.
  task automatic run_frame(input string name, input logic [23:0] base, input int drop_at,
                           input int sof_at, input int clr_a, input int clr_b, input int stop_at);
    int          nxt;
    bit          a;
    bit          mis;
    bit          err;
    bit          sync;
    bit          exp_ready;
    logic [23:0] exp_rgb;
    nxt = 0;
    for (int c = 0; c < FT; c++) begin
      if (c == stop_at) begin
        clr_underflow = 1'b0;
        return;
      end
      a = f_act(c);
      clr_underflow = (c == clr_a) || (c == clr_b);
      if (exp_run) begin
        s_valid = (nxt != drop_at);
        s_sof   = (nxt == 0) || (nxt == sof_at);
        s_data  = base + 24'(nxt);
      end else if (c == 0) begin
        s_valid = 1'b1;
        s_sof   = 1'b1;
        s_data  = base;
      end else begin
        s_valid = (wait_mode != 0);
        s_sof   = (wait_mode == 2);
        s_data  = 24'hDD0000 + 24'(c);
      end
      #1;
      exp_rgb = 24'h000000;
      err     = 1'b0;
      sync    = 1'b0;
      if (exp_run) begin
        mis       = s_valid && s_sof && (c != 0);
        exp_ready = a && !mis;
        if (a && s_valid && !mis) begin
          exp_rgb = base + 24'(nxt);
          $display("xfer %s pos=%0d pix=%0d data=%06h", name, c, nxt, s_data);
          nxt++;
        end else if (a) begin
          err       = 1'b1;
          wait_mode = mis ? 2 : 1;
        end
      end else if (c == 0) begin
        exp_ready = 1'b1;
        sync      = 1'b1;
        exp_rgb   = base;
        $display("xfer %s pos=%0d pix=%0d data=%06h (sof)", name, c, nxt, s_data);
        nxt++;
      end else begin
        exp_ready = s_valid && !s_sof;
      end
      check({name, "_ready"}, 32'(s_ready), 32'(exp_ready));
      if (err) exp_uf = 1'b1;
      else if (clr_underflow) exp_uf = 1'b0;
      if (err) exp_run = 1'b0;
      if (sync) exp_run = 1'b1;
      tick();
      check_rgb({name, "_rgb"}, exp_rgb);
      check_timing({name, "_timing"});
      check({name, "_uf"}, 32'(underflow), 32'(exp_uf));
    end
    clr_underflow = 1'b0;
  endtask

  initial begin
    int fs_count;
    logic [23:0] pat [8];

    rstin_n = 1'b0;
    enable = 1'b0;
    s_data = 24'h000000;
    s_valid = 1'b0;
    s_sof = 1'b0;
    clr_underflow = 1'b0;
`ifdef DVI_TEST_PATTERN_EN
    pattern_sel = 1'b0;
`endif

    // Reset state
    repeat (3) tick();
    check_rgb("rst_rgb", 24'h000000);
    check("rst_timing", 32'({de, hsync, vsync, frame_start}), 32'h0);
    check("rst_uf", 32'(underflow), 32'h0);
    rstin_n = 1'b1;
    tick();
    s_valid = 1'b1;
    #1;
    check("idle_ready", 32'(s_ready), 32'h0);
    s_valid = 1'b0;

    // Free-running timing, no upstream data
    enable = 1'b1;
    fs_count = 0;
    for (int i = 0; i < FT; i++) begin
      tick();
      check_timing("t1_timing");
      check_rgb("t1_rgb", 24'h000000);
      check("t1_uf", 32'(underflow), 32'h0);
      if (frame_start) fs_count++;
    end
    check("t1_fs_count", 32'(fs_count), 32'd1);
    $display("phase timing: %0d frame_start pulses in %0d clocks", fs_count, FT);

    // Source holds its SOF pixel before the raster reaches (0,0)
    for (int i = 0; i < 90; i++) tick();
    s_valid = 1'b1;
    s_sof = 1'b1;
    s_data = 24'h000000;
    while (pos != 0) begin
      #1;
      check("hold_ready", 32'(s_ready), 32'h0);
      tick();
      check_timing("hold_timing");
      check_rgb("hold_rgb", 24'h000000);
    end

    // Frame A: 32 pixels, value = index
    exp_run = 1'b0;
    exp_uf = 1'b0;
    run_frame("fa", 24'h000000, -1, -1, -1, -1, -1);
    // Frame B: valid drops at pixel 5 -> underflow, then drain
    run_frame("fb", 24'h100000, 5, -1, -1, -1, -1);
    // Frame C: clear flag, then stray SOF on pixel 12 together with a clear
    run_frame("fc", 24'h200000, -1, 12, 8, 18, -1);
    // Frame D: resyncs at (0,0); stop mid-line 1
    run_frame("fd", 24'h300000, -1, -1, -1, -1, 18);

    // Disable mid-line while running
    enable = 1'b0;
    s_valid = 1'b1;
    s_sof = 1'b0;
    #1;
    check("dis_ready", 32'(s_ready), 32'h0);
    repeat (3) begin
      tick();
      check_rgb("dis_rgb", 24'h000000);
      check_timing("dis_timing");
      check("dis_uf_kept", 32'(underflow), 32'h1);
    end

    // Re-enable: restart at (0,0) in WAIT_SOF
    enable = 1'b1;
    s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_timing("re_timing");
      check_rgb("re_rgb", 24'h000000);
    end
    s_valid = 1'b1;
    s_sof = 1'b0;
    #1;
    check("re_wait_ready", 32'(s_ready), 32'h1);
    repeat (3) tick();
    s_valid = 1'b0;
    check("pre_rst_pos", 32'(last_pos), 32'd10);
    check_timing("pre_rst_timing");

    // Asynchronous reset mid-frame
    #2;
    rstin_n = 1'b0;
    #1;
    check("arst_timing", 32'({de, hsync, vsync, frame_start}), 32'h0);
    check("arst_uf", 32'(underflow), 32'h0);
    check_rgb("arst_rgb", 24'h000000);
    tick();
    rstin_n = 1'b1;
    tick();
    check("rst_restart_fs", 32'({de, frame_start}), 32'h3);
    while (pos != 8) tick();
    s_valid = 1'b1;
    #1;
    check("rst_wait_ready", 32'(s_ready), 32'h1);
    s_valid = 1'b0;

`ifdef DVI_TEST_PATTERN_EN
    // Colour bars
    pat[0] = 24'hFFFFFF; pat[1] = 24'hFFFF00; pat[2] = 24'h00FFFF; pat[3] = 24'h00FF00;
    pat[4] = 24'hFF00FF; pat[5] = 24'hFF0000; pat[6] = 24'h0000FF; pat[7] = 24'h000000;
    enable = 1'b0;
    tick();
    pattern_sel = 1'b1;
    enable = 1'b1;
    s_valid = 1'b1;
    s_sof = 1'b0;
    for (int c = 0; c < HT; c++) begin
      #1;
      check("pat_ready", 32'(s_ready), 32'h0);
      tick();
      check_rgb("pat_rgb", (c < 8) ? pat[c] : 24'h000000);
      check_timing("pat_timing");
      $display("pattern pos=%0d rgb=%02h%02h%02h", c, red_out, green_out, blue_out);
    end
    pattern_sel = 1'b0;
    s_valid = 1'b0;
`else
    pat[0] = 24'h000000;
    if (pat[0] != 24'h000000) $display("pattern table unused");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
